alsaqr_rst_seq: RTL and testbench
=================================

ALSAQR_RST_SEQ -- requirements
Module: alsaqr_rst_seq

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 4, number of sequenced reset domains (1..16).
REQ-002 SHALL have parameter CNT_W, default 8, width of per-domain release-delay counter.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchroniser depth for rst_req_i (>=2).
REQ-004 clk_i  in  1  single clock; all sequential logic on rising edge.
REQ-005 rst_ni  in  1  asynchronous active-low reset.
REQ-006 test_mode_i  in  1  scan/test bypass.
REQ-007 rst_req_i  in  NUM_DOMAINS  asynchronous per-domain reset request, active-high (e.g. debug-module reset).
REQ-008 dly_i  in  NUM_DOMAINS x CNT_W  per-domain release delay, quasi-static.
REQ-009 rstn_o  out  NUM_DOMAINS  per-domain active-low reset, domain 0 released first.
REQ-010 busy_o  out  1  high while any domain is held or sequencing.
REQ-011 done_o  out  1  high when all domains released and no request pending.

Function
REQ-012 FSM states: HOLD, RELEASE, RUN, ASSERT; encoding from shared package.
REQ-013 HOLD -> RELEASE on first clk_i edge after rst_ni deassertion; idx<=0, cnt<=dly_i[0].
REQ-014 RELEASE: cnt!=0 -> cnt decrements; cnt==0 -> rstn_o[idx]<=1; if idx<NUM_DOMAINS-1 then idx+1 and cnt<=dly_i[idx+1], else -> RUN.
REQ-015 Timing: rstn_o[0] rises dly_i[0]+2 edges after rst_ni deassertion; rstn_o[k] rises dly_i[k]+1 edges after rstn_o[k-1].
REQ-016 dly_i[k] sampled only when loading domain k; later changes do not affect the running count.
REQ-017 Dependency order: rstn_o[k]==1 implies rstn_o[j]==1 for all j<k, at every cycle outside test mode.
REQ-018 rst_req_i passes through SYNC_STAGES flops (async reset to 0) before use; raw input never drives logic.
REQ-019 RUN: any synchronised request with lowest set index m -> rstn_o[NUM_DOMAINS-1:m]<=0 on next edge, state -> ASSERT, idx<=m.
REQ-020 ASSERT: held while any synchronised request set; a new lower index m' lowers idx to m' and asserts domains >= m' on next edge; on all requests clear -> RELEASE with cnt<=dly_i[idx].
REQ-021 Request arriving during RELEASE with lowest index m<=idx: domains >= m asserted next edge, idx<=m, -> ASSERT; requests with index >idx ignored (domain already held).
REQ-022 Simultaneous cnt==0 and qualifying request in RELEASE: request wins, domain idx not released.
REQ-023 Request-to-rstn_o fall latency: SYNC_STAGES+1 edges.
REQ-024 busy_o = (state != RUN); done_o = (state == RUN); both registered-state-derived, glitch-free.
REQ-025 NUM_DOMAINS==1: RELEASE exits to RUN directly after domain 0.
REQ-026 test_mode_i=1: rstn_o[k] = rst_ni for all k combinationally; FSM keeps running internally; busy_o/done_o unaffected.

Reset
REQ-027 rst_ni low: state=HOLD, idx=0, cnt=0, sync flops=0, rstn_o=all 0, busy_o=1, done_o=0, asynchronously.
REQ-028 rst_ni assertion mid-sequence or mid-ASSERT aborts immediately; sequence restarts from domain 0 after deassertion.
REQ-029 rstn_o deassertion always synchronous to clk_i; assertion via rst_ni asynchronous.

Structure
REQ-030 Package alsaqr_rst_pkg SHALL hold the FSM state enum and default parameter constants (NUM_DOMAINS, CNT_W, SYNC_STAGES).
REQ-031 One sub-module alsaqr_rst_req_sync: SYNC_STAGES-deep per-bit synchroniser, instantiated NUM_DOMAINS-wide.
REQ-032 rstn_o driven from one flop per domain, muxed only by test_mode_i.

Verification (NUM_DOMAINS=4, CNT_W=8, SYNC_STAGES=2)
REQ-033 dly_i={3,0,5,1} (domain 0..3), release rst_ni -> rstn_o[0..3] rise at edges 5,6,12,14; done_o high at edge 14.
REQ-034 In RUN, pulse rst_req_i[2] 4 cycles -> rstn_o[3:2]=0 3 edges after rise, rstn_o[1:0] stay 1; after clear, rstn_o[2] rises dly_i[2]+1 edges later, then rstn_o[3].
REQ-035 During RELEASE at idx=2, assert rst_req_i[1] -> rstn_o[3:1]=0, idx restarts at 1; assert rst_req_i[3] at idx=1 -> no change.
REQ-036 Assert rst_ni low while idx=2, cnt=3 -> all rstn_o=0 same cycle, busy_o=1; re-release -> full sequence per REQ-033.
REQ-037 test_mode_i=1, toggle rst_ni -> rstn_o follows rst_ni on all 4 bits with zero cycles latency.
REQ-038 Random requests/delays, assertion checks REQ-017 ordering and REQ-024 busy_o/done_o exclusivity every cycle.

Source files
------------

// File: rtl/alsaqr_rst_pkg.sv
// alsaqr_rst_pkg
//   Shared definitions for the reset sequencer: FSM state encoding and the
//   default values of the sequencer parameters.
package alsaqr_rst_pkg;

    localparam int unsigned NUM_DOMAINS_DEF = 4;
    localparam int unsigned CNT_W_DEF       = 8;
    localparam int unsigned SYNC_STAGES_DEF = 2;

    // HOLD    : rst_ni asserted, everything held
    // RELEASE : walking domains upward, counting each domain's delay
    // RUN     : all domains released
    // ASSERT  : a request is holding domains idx and above in reset
    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2,
        ASSERT  = 2'd3
    } rst_state_e;

endpackage

// File: rtl/alsaqr_rst_req_sync.sv
// alsaqr_rst_req_sync
//   Single-bit STAGES-deep synchroniser for an asynchronous reset request.
//   Ports:
//     clk_i  - sampling clock
//     rst_ni - asynchronous active-low reset, clears the chain to 0
//     d_i    - asynchronous input
//     q_o    - synchronised output (STAGES edges of latency)
module alsaqr_rst_req_sync
    import alsaqr_rst_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/alsaqr_rst_seq.sv
// alsaqr_rst_seq
//   Ordered reset release for NUM_DOMAINS reset domains. After rst_ni
//   deasserts, domain 0 is released first, then each following domain after
//   its own programmable delay. Per-domain requests re-assert the requested
//   domain and every domain above it, then re-run the release from there.
//   Ports:
//     clk_i       - clock
//     rst_ni      - asynchronous active-low reset
//     test_mode_i - bypass: every rstn_o follows rst_ni directly
//     rst_req_i   - asynchronous per-domain reset requests, active high
//     dly_i       - per-domain release delay, sampled when the domain is loaded
//     rstn_o      - per-domain active-low resets
//     busy_o      - sequencer not in RUN
//     done_o      - sequencer in RUN (all released, no request pending)
module alsaqr_rst_seq
    import alsaqr_rst_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS = NUM_DOMAINS_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               test_mode_i,
    input  logic [NUM_DOMAINS-1:0]             rst_req_i,
    input  logic [NUM_DOMAINS-1:0][CNT_W-1:0]  dly_i,
    output logic [NUM_DOMAINS-1:0]             rstn_o,
    output logic                               busy_o,
    output logic                               done_o
);

    localparam int unsigned     IDX_W    = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

    rst_state_e                 state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0]     rstn_q, rstn_d;

    logic [NUM_DOMAINS-1:0]     req_sync;
    logic                       req_any;
    logic [IDX_W-1:0]           req_idx;
    logic [IDX_W-1:0]           idx_nxt;

    // Mask that keeps domains below m and clears m and everything above it.
    function automatic logic [NUM_DOMAINS-1:0] keep_below(input logic [IDX_W-1:0] m);
        logic [NUM_DOMAINS-1:0] mask;
        mask = '0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            mask[i] = (i < int'(m));
        end
        return mask;
    endfunction

    for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_req_sync
        alsaqr_rst_req_sync #(
            .STAGES (SYNC_STAGES)
        ) i_req_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (rst_req_i[k]),
            .q_o    (req_sync[k])
        );
    end

    // Lowest requesting domain decides how far down the reset reaches.
    always_comb begin
        req_any = |req_sync;
        req_idx = '0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (req_sync[i]) req_idx = IDX_W'(i);
        end
    end

    assign idx_nxt = idx_q + IDX_W'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HOLD;
            idx_q   <= '0;
            cnt_q   <= '0;
            rstn_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rstn_q  <= rstn_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rstn_d  = rstn_q;
        unique case (state_q)
            HOLD: begin
                state_d = RELEASE;
                idx_d   = '0;
                cnt_d   = dly_i[0];
            end
            RELEASE: begin
                // Domains at and above idx are still held, so only a request
                // at or below idx changes anything; it also beats a release
                // that would happen on the same edge.
                if (req_any && (req_idx <= idx_q)) begin
                    state_d = ASSERT;
                    idx_d   = req_idx;
                    rstn_d  = rstn_q & keep_below(req_idx);
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    rstn_d[idx_q] = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = RUN;
                    end else begin
                        idx_d = idx_nxt;
                        cnt_d = dly_i[idx_nxt];
                    end
                end
            end
            RUN: begin
                if (req_any) begin
                    state_d = ASSERT;
                    idx_d   = req_idx;
                    rstn_d  = rstn_q & keep_below(req_idx);
                end
            end
            ASSERT: begin
                if (!req_any) begin
                    state_d = RELEASE;
                    cnt_d   = dly_i[idx_q];
                end else if (req_idx < idx_q) begin
                    idx_d  = req_idx;
                    rstn_d = rstn_q & keep_below(req_idx);
                end
            end
            default: begin
                state_d = HOLD;
            end
        endcase
    end

    // Status comes straight from the state flops; the rstn flops are only
    // bypassed by test mode so assertion via rst_ni stays asynchronous there.
    always_comb begin
        busy_o = (state_q != RUN);
        done_o = (state_q == RUN);
        rstn_o = test_mode_i ? {NUM_DOMAINS{rst_ni}} : rstn_q;
    end

endmodule

// File: tb/tb_alsaqr_rst_seq.sv
module tb_alsaqr_rst_seq;

    localparam int ND = 4;
    localparam int CW = 8;

    logic                     clk   = 1'b0;
    logic                     rst_n = 1'b1;
    logic                     tm    = 1'b0;
    logic [ND-1:0]            req   = '0;
    logic [ND-1:0][CW-1:0]    dly   = '0;
    logic [ND-1:0]            rstn;
    logic                     busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    alsaqr_rst_seq #(
        .NUM_DOMAINS (ND),
        .CNT_W       (CW),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .test_mode_i (tm),
        .rst_req_i   (req),
        .dly_i       (dly),
        .rstn_o      (rstn),
        .busy_o      (busy),
        .done_o      (done)
    );

    typedef struct {
        logic       rst_n;
        logic       tm;
        logic [3:0] req;
        logic [3:0] rstn;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic t, input logic [3:0] q,
                       input logic [3:0] er, input logic eb, input logic ed, input int reps);
        vec_t v;
        v.rst_n = r; v.tm = t; v.req = q; v.rstn = er; v.busy = eb; v.done = ed;
        for (int i = 0; i < reps; i++) vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [3:0] er, input logic eb, input logic ed);
        n_cmp++;
        if (rstn !== er || busy !== eb || done !== ed) begin
            n_bad++;
            $display("FAIL %s: got rstn=%b busy=%b done=%b, expected rstn=%b busy=%b done=%b",
                     name, rstn, busy, done, er, eb, ed);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = CW'(d0); dly[1] = CW'(d1); dly[2] = CW'(d2); dly[3] = CW'(d3);
    endtask

    // Hold reset for two edges, release right after an edge: the next edge is edge 1.
    task automatic do_release();
        rst_n = 1'b0;
        req   = '0;
        step(2);
        rst_n = 1'b1;
    endtask

    // Ordering and busy/done exclusivity, every cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            n_cmp++;
            if (!tm && (((rstn + 4'd1) & rstn) != 4'd0)) begin
                n_bad++;
                $display("FAIL order: rstn=%b is not a contiguous low-side run", rstn);
            end
            n_cmp++;
            if (busy === done) begin
                n_bad++;
                $display("FAIL busy_done_excl: busy=%b done=%b, expected opposite values", busy, done);
            end
        end
    end

    initial begin
        // async reset before any clock edge
        #2 rst_n = 1'b0;
        #1 chk("reset_async", 4'b0000, 1'b1, 1'b0);
        mon_en = 1'b1;

        // ---- table: full release with {3,0,5,1}, then a 4-cycle request on domain 2
        set_dly(3, 0, 5, 1);
        add(0, 0, 4'b0000, 4'b0000, 1, 0, 2);
        add(1, 0, 4'b0000, 4'b0000, 1, 0, 4);   // edges 1-4
        add(1, 0, 4'b0000, 4'b0001, 1, 0, 1);   // edge 5
        add(1, 0, 4'b0000, 4'b0011, 1, 0, 6);   // edges 6-11
        add(1, 0, 4'b0000, 4'b0111, 1, 0, 2);   // edges 12-13
        add(1, 0, 4'b0000, 4'b1111, 0, 1, 2);   // edges 14-15
        add(1, 0, 4'b0100, 4'b1111, 0, 1, 2);   // req still in synchroniser
        add(1, 0, 4'b0100, 4'b0011, 1, 0, 2);   // third edge after request rise
        add(1, 0, 4'b0000, 4'b0011, 1, 0, 8);   // held, then counting dly[2]
        add(1, 0, 4'b0000, 4'b0111, 1, 0, 2);
        add(1, 0, 4'b0000, 4'b1111, 0, 1, 2);
        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n;
            tm    = vecs[i].tm;
            req   = vecs[i].req;
            step(1);
            chk($sformatf("vec%0d", i), vecs[i].rstn, vecs[i].busy, vecs[i].done);
        end
        req = '0;

        // ---- request observed on the same edge domain 0 would release
        set_dly(3, 0, 5, 1);
        do_release();
        step(2);
        req = 4'b0001;
        step(1);
        req = 4'b0000;
        step(2);
        chk("req_beats_release", 4'b0000, 1'b1, 1'b0);
        step(4);
        chk("still_counting", 4'b0000, 1'b1, 1'b0);
        step(1);
        chk("rel0_after_req", 4'b0001, 1'b1, 1'b0);

        // ---- request below idx restarts from it; request above idx ignored
        set_dly(1, 4, 4, 1);
        do_release();
        step(8);
        chk("at_idx2", 4'b0011, 1'b1, 1'b0);
        req = 4'b0010;
        step(2);
        chk("req1_latency", 4'b0011, 1'b1, 1'b0);
        step(1);
        chk("req1_assert", 4'b0001, 1'b1, 1'b0);
        req = 4'b0000;
        step(3);
        chk("req1_released_req", 4'b0001, 1'b1, 1'b0);
        req = 4'b1000;
        step(2);
        req = 4'b0000;
        step(2);
        chk("req3_ignored", 4'b0001, 1'b1, 1'b0);
        step(1);
        chk("rel1_again", 4'b0011, 1'b1, 1'b0);
        step(7);
        chk("rerun_done", 4'b1111, 1'b0, 1'b1);

        // ---- rst_ni abort at idx=2, cnt=3, then full re-run
        set_dly(3, 0, 5, 1);
        do_release();
        step(8);
        chk("pre_abort", 4'b0011, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1 chk("abort_async", 4'b0000, 1'b1, 1'b0);
        step(2);
        rst_n = 1'b1;
        step(4);
        chk("rerun_e4", 4'b0000, 1'b1, 1'b0);
        step(1);
        chk("rerun_e5", 4'b0001, 1'b1, 1'b0);
        step(6);
        chk("rerun_e11", 4'b0011, 1'b1, 1'b0);
        step(1);
        chk("rerun_e12", 4'b0111, 1'b1, 1'b0);
        step(2);
        chk("rerun_e14", 4'b1111, 1'b0, 1'b1);

        // ---- test mode: rstn_o follows rst_ni with no clock edge
        tm = 1'b1;
        #1 chk("tm_run", 4'b1111, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1 chk("tm_rst_low", 4'b0000, 1'b1, 1'b0);
        rst_n = 1'b1;
        #1 chk("tm_rst_high", 4'b1111, 1'b1, 1'b0);
        step(1);
        chk("tm_fsm_runs", 4'b1111, 1'b1, 1'b0);
        tm = 1'b0;
        #1 chk("tm_off", 4'b0000, 1'b1, 1'b0);
        step(13);
        chk("tm_seq_ran", 4'b1111, 1'b0, 1'b1);

        // ---- random requests, delays and occasional resets under the monitor
        for (int r = 0; r < 300; r++) begin
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < ND; k++) dly[k] = CW'($urandom_range(0, 6));
            end
            if ($urandom_range(0, 31) == 0) begin
                rst_n = 1'b0;
                step(1);
                rst_n = 1'b1;
            end
            req = ($urandom_range(0, 2) == 0) ? ND'($urandom_range(0, 15)) : '0;
            step($urandom_range(1, 6));
        end
        req = '0;
        rst_n = 1'b1;
        step(80);
        chk("random_settle", 4'b1111, 1'b0, 1'b1);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
